// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch slice: data width, NOP encoding and the
// {instruction, PC} entry carried through the fetch queues.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch entries with flush; read/write pointers carry an
// extra wrap bit so full and empty are distinguishable without a separate counter.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] PTR_ONE = 1;

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // On a full buffer a same-cycle push overwrites the slot being popped, which is safe
  // because the popped head has already been consumed combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order word requests, pairs returned words with
// their PCs and hands {instruction, PC} to decode; redirects discard wrong-path fetches.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instruct,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int SUM_W = AW + 2;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W-1:0] inflight_count;
  logic [CNT_W-1:0] buf_count;
  logic [SUM_W-1:0] occupancy;
  logic             inflight_full;
  logic             inflight_empty;
  logic             buf_full;
  logic             buf_empty;
  logic             req_fire;
  logic             rsp_keep;
  logic             buf_push;
  logic             buf_pop;
  fetch_entry_t     req_entry;
  fetch_entry_t     rsp_entry;
  fetch_entry_t     inflight_head;
  fetch_entry_t     buf_head;
  logic             unused_ok;

  // Credit uses registered counts only, so stall/redirect never reach req_valid.
  assign occupancy        = SUM_W'(inflight_count) + SUM_W'(buf_count);
  assign o_imem_req_valid = rst && (occupancy < SUM_W'(DEPTH));
  assign o_imem_addr      = pc;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  assign rsp_keep  = i_imem_rsp_valid && (drop_count == '0);
  assign buf_push  = rsp_keep && !i_redirect;
  assign buf_pop   = !buf_empty && !i_stall && !i_redirect;
  assign drop_next = inflight_count + CNT_W'(req_fire) - CNT_W'(i_imem_rsp_valid);

  assign req_entry = '{instr: INSTR_NOP, pc: pc};
  assign rsp_entry = '{instr: i_imem_rdata, pc: inflight_head.pc};

  assign o_valid    = !buf_empty;
  assign o_instruct = buf_head.instr;
  assign o_pc       = buf_head.pc;
  assign o_pc_plus4 = buf_head.pc + 32'd4;

  assign unused_ok = ^{inflight_head.instr, i_redirect_pc[1:0], inflight_full,
                       inflight_empty, buf_full};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (i_redirect) begin
      pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      pc <= pc + 32'd4;
    end
  end

  // Everything still outstanding after a redirect, including a request accepted in
  // the same cycle, belongs to the wrong path and must be swallowed on return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (i_redirect) begin
      drop_count <= drop_next;
    end else if (i_imem_rsp_valid && (drop_count != '0)) begin
      drop_count <= drop_count - CNT_ONE;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (req_entry),
    .pop       (i_imem_rsp_valid),
    .flush     (1'b0),
    .head      (inflight_head),
    .full      (inflight_full),
    .empty     (inflight_empty),
    .count     (inflight_count)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (rsp_entry),
    .pop       (buf_pop),
    .flush     (i_redirect),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural memory plus an expected-stream
// model (in-order PCs restarting at each redirect) checked by a separate monitor.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        o_imem_req_valid;
  logic [31:0] o_imem_addr;
  logic        i_imem_req_ready = 1'b0;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_stall = 1'b0;
  logic        o_valid;
  logic [31:0] o_instruct;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_addr      (o_imem_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rdata     (i_imem_rdata),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .i_stall          (i_stall),
    .o_valid          (o_valid),
    .o_instruct       (o_instruct),
    .o_pc             (o_pc),
    .o_pc_plus4       (o_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mem_req_t;

  exp_t        sb_q[$];
  mem_req_t    mem_q[$];
  logic [31:0] model_pc = RESET_PC;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          rdy_pct = 100;
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: condition not met", name);
  endtask

  // One clock cycle: drive inputs and the memory response at the falling edge, then
  // account for what the DUT will accept on the coming rising edge.
  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] target);
    @(negedge clk);
    cyc++;
    i_stall          = stall;
    i_redirect       = redir;
    i_redirect_pc    = target;
    i_imem_req_ready = ($urandom_range(99) < rdy_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rdata     = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rdata     = $urandom;
    end
    #2;
    if (o_imem_req_valid) checkOutput("o_imem_addr", o_imem_addr, model_pc);
    if (o_imem_req_valid && i_imem_req_ready) begin
      mem_q.push_back('{addr: o_imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      sb_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (redir) begin
      sb_q.delete();
      model_pc = {target[31:2], 2'b00};
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rst_o_valid", 32'(o_valid), 32'h0);
    checkOutput("rst_req_valid", 32'(o_imem_req_valid), 32'h0);
    checkOutput("rst_o_instruct", o_instruct, 32'h0);
    checkOutput("rst_o_pc", o_pc, 32'h0);
    checkOutput("rst_o_pc_plus4", o_pc_plus4, 32'h4);
    mem_q.delete();
    sb_q.delete();
    model_pc         = RESET_PC;
    i_stall          = 1'b0;
    i_redirect       = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_req_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic waitValid(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (o_valid) begin
        checkOutput(name, o_pc, exp_pc);
        seen = 1'b1;
      end
    end
    if (!seen) failNow({name, "_timeout"});
  endtask

  // Monitor: every presented entry must match the oldest expected fetch; it retires
  // only when decode actually takes it.
  always @(negedge clk) begin
    #1;
    if (rst && o_valid) begin
      if (sb_q.size() == 0) begin
        failNow("unexpected_o_valid");
      end else begin
        checkOutput("o_pc", o_pc, sb_q[0].pc);
        checkOutput("o_instruct", o_instruct, sb_q[0].instr);
        checkOutput("o_pc_plus4", o_pc_plus4, sb_q[0].pc + 32'd4);
        if (!i_stall && !i_redirect) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first;
    bit seen;

    // Streaming with always-ready, single-cycle memory.
    applyReset();
    first = 0;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (k == 1) checkOutput("req_valid_cycle1", 32'(o_imem_req_valid), 32'h1);
      if (o_valid && first == 0) first = k;
    end
    checkOutput("first_valid_cycle", first, 3);
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Decode stall: buffer fills and requests stop; order resumes afterwards.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stall_o_valid", 32'(o_valid), 32'h1);
    checkOutput("stall_req_valid", 32'(o_imem_req_valid), 32'h0);
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Redirect with two requests in flight on a 3-cycle memory.
    applyReset();
    lat_min = 3;
    lat_max = 3;
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100);
    waitValid("redirect_first_pc", 32'h100);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Redirect to a misaligned target while decode is stalled.
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h103);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("flush_o_valid", 32'(o_valid), 32'h0);
    waitValid("redirect_stall_pc", 32'h100);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Random memory backpressure, latency, stalls and redirects.
    rdy_pct = 60;
    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) < 3) applyStimulus($urandom_range(99) < 25, 1'b1, $urandom);
      else applyStimulus($urandom_range(99) < 25, 1'b0, 32'h0);
    end

    // Reset in the middle of the stream.
    applyReset();
    rdy_pct = 100;
    lat_min = 1;
    lat_max = 2;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post_reset_addr", o_imem_addr, RESET_PC);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 32'h0);

    // PC wrap across the top of the address space.
    lat_max = 1;
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
    waitValid("wrap_first_pc", 32'hFFFF_FFF8);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (o_valid && o_pc == 32'hFFFF_FFFC) begin
        checkOutput("wrap_plus4", o_pc_plus4, 32'h0);
        seen = 1'b1;
      end
    end
    if (!seen) failNow("wrap_timeout");
    waitValid("wrap_zero_pc", 32'h0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
